// File: rtl/turn_controller_if.sv
// Connect-four controller bus: front-end/engine/checker inputs and board/status outputs.
// btn_undo exists only when UNDO_EN is defined.
interface turn_controller_if;
    logic        sw;
    logic        btn_drop;
    logic [2:0]  sel_col;
    logic        ai_move;
    logic [6:0]  ai_opt;
    logic        win_p1;
    logic        win_p2;
`ifdef UNDO_EN
    logic        btn_undo;
`endif
    logic [97:0] grid;
    logic [20:0] column_counts;
    logic        player;
    logic        game_over;
    logic [1:0]  winner;
    logic        illegal;

    modport master (
`ifdef UNDO_EN
        output btn_undo,
`endif
        output sw, btn_drop, sel_col, ai_move, ai_opt, win_p1, win_p2,
        input  grid, column_counts, player, game_over, winner, illegal
    );

    modport slave (
`ifdef UNDO_EN
        input  btn_undo,
`endif
        input  sw, btn_drop, sel_col, ai_move, ai_opt, win_p1, win_p2,
        output grid, column_counts, player, game_over, winner, illegal
    );
endinterface

// File: rtl/turn_controller.sv
// Connect-four game sequencer: owns the board and turn flag, validates human drops,
// applies minimax moves (with timeout fallback) and freezes the game on win/draw.
// Optional feature macro: UNDO_EN (btn_undo with a 2-deep column history).
module turn_controller (
    input  logic             clk,
    input  logic             rst,
    turn_controller_if.slave bus
);
    localparam int unsigned AI_TIMEOUT   = 255;
    localparam int unsigned MAX_HEIGHT   = 6;
    localparam int unsigned CHECK_CYCLES = 2;
    localparam int unsigned NUM_COLS     = 7;

    typedef enum logic [2:0] {WAIT_P1, WAIT_P2, AI_WAIT, WRITE, CHECK, DONE} state_t;

    state_t     state;
    logic [2:0] w_col;
    logic [1:0] w_piece;
    logic       mover;
    logic [1:0] chk_cnt;
    logic [7:0] ai_timer;

    logic [6:0] ai_mod_c;
    logic [2:0] ai_col_c;
    logic [2:0] fallback_col_c;
    logic       sel_legal_c;
    logic       ai_legal_c;
    logic       board_full_c;

    function automatic logic [2:0] count_of(input logic [20:0] cc, input logic [2:0] c);
        return cc[5'(c) * 5'd3 +: 3];
    endfunction

    // LSB of the 2-bit field for cell (c,r)
    function automatic logic [6:0] cell_lsb(input logic [2:0] c, input logic [2:0] r);
        return 7'(r) * 7'd14 + 7'd12 - {3'b000, c, 1'b0};
    endfunction

    // Move legality, engine column decode, fallback column and full-board detect
    always_comb begin
        sel_legal_c    = (bus.sel_col < 3'd7) &&
                         (count_of(bus.column_counts, bus.sel_col) < 3'(MAX_HEIGHT));
        ai_mod_c       = bus.ai_opt % 7'd14;
        ai_col_c       = 3'((7'd13 - ai_mod_c) >> 1);
        ai_legal_c     = count_of(bus.column_counts, ai_col_c) < 3'(MAX_HEIGHT);
        board_full_c   = 1'b1;
        fallback_col_c = 3'd0;
        for (int i = NUM_COLS - 1; i >= 0; i--) begin
            if (count_of(bus.column_counts, 3'(i)) < 3'(MAX_HEIGHT)) begin
                fallback_col_c = 3'(i);
                board_full_c   = 1'b0;
            end
        end
    end

`ifdef UNDO_EN
    logic [2:0] hist_col [2];
    logic [1:0] hist_cnt;
    logic       undo_go_c;
    logic [2:0] h0_cnt_c;
    logic [2:0] h1_cnt_c;

    // Undo is accepted only on a human turn with something to pop
    always_comb begin
        undo_go_c = bus.btn_undo && (hist_cnt != 2'd0) &&
                    ((state == WAIT_P1) || ((state == WAIT_P2) && !bus.sw));
        h0_cnt_c  = count_of(bus.column_counts, hist_col[0]);
        h1_cnt_c  = count_of(bus.column_counts, hist_col[1]);
    end
`endif

    // Game FSM with registered board and status outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state             <= WAIT_P1;
            w_col             <= 3'd0;
            w_piece           <= 2'b00;
            mover             <= 1'b0;
            chk_cnt           <= 2'd0;
            ai_timer          <= 8'd0;
            bus.grid          <= '0;
            bus.column_counts <= '0;
            bus.player        <= 1'b0;
            bus.game_over     <= 1'b0;
            bus.winner        <= 2'b00;
            bus.illegal       <= 1'b0;
`ifdef UNDO_EN
            hist_col[0]       <= 3'd0;
            hist_col[1]       <= 3'd0;
            hist_cnt          <= 2'd0;
`endif
        end else begin
            bus.illegal <= 1'b0;
            case (state)
                WAIT_P1, WAIT_P2: begin
`ifdef UNDO_EN
                    if (undo_go_c) begin
                        if (bus.sw && (hist_cnt == 2'd2)) begin
                            if (hist_col[0] == hist_col[1]) begin
                                bus.grid[cell_lsb(hist_col[0], h0_cnt_c - 3'd1) +: 2] <= 2'b00;
                                bus.grid[cell_lsb(hist_col[0], h0_cnt_c - 3'd2) +: 2] <= 2'b00;
                                bus.column_counts[5'(hist_col[0]) * 5'd3 +: 3] <= h0_cnt_c - 3'd2;
                            end else begin
                                bus.grid[cell_lsb(hist_col[0], h0_cnt_c - 3'd1) +: 2] <= 2'b00;
                                bus.grid[cell_lsb(hist_col[1], h1_cnt_c - 3'd1) +: 2] <= 2'b00;
                                bus.column_counts[5'(hist_col[0]) * 5'd3 +: 3] <= h0_cnt_c - 3'd1;
                                bus.column_counts[5'(hist_col[1]) * 5'd3 +: 3] <= h1_cnt_c - 3'd1;
                            end
                            hist_cnt <= 2'd0;
                        end else begin
                            bus.grid[cell_lsb(hist_col[0], h0_cnt_c - 3'd1) +: 2] <= 2'b00;
                            bus.column_counts[5'(hist_col[0]) * 5'd3 +: 3] <= h0_cnt_c - 3'd1;
                            hist_col[0] <= hist_col[1];
                            hist_cnt    <= hist_cnt - 2'd1;
                            if (!bus.sw) begin
                                bus.player <= ~bus.player;
                                state      <= (state == WAIT_P1) ? WAIT_P2 : WAIT_P1;
                            end
                        end
                    end else
`endif
                    if (bus.btn_drop) begin
                        if (sel_legal_c) begin
                            w_col   <= bus.sel_col;
                            w_piece <= (state == WAIT_P1) ? 2'b01 : 2'b10;
                            mover   <= (state == WAIT_P2);
                            state   <= WRITE;
                        end else begin
                            bus.illegal <= 1'b1;
                        end
                    end
                end
                AI_WAIT: begin
                    if (!bus.sw) begin
                        state <= WAIT_P2;
                    end else if (bus.ai_move && ai_legal_c) begin
                        w_col   <= ai_col_c;
                        w_piece <= 2'b10;
                        mover   <= 1'b1;
                        state   <= WRITE;
                    end else if (bus.ai_move || (ai_timer == 8'(AI_TIMEOUT))) begin
                        w_col   <= fallback_col_c;
                        w_piece <= 2'b10;
                        mover   <= 1'b1;
                        state   <= WRITE;
                    end else begin
                        ai_timer <= ai_timer + 8'd1;
                    end
                end
                WRITE: begin
                    bus.grid[cell_lsb(w_col, count_of(bus.column_counts, w_col)) +: 2] <= w_piece;
                    bus.column_counts[5'(w_col) * 5'd3 +: 3] <=
                        count_of(bus.column_counts, w_col) + 3'd1;
`ifdef UNDO_EN
                    hist_col[0] <= w_col;
                    hist_col[1] <= hist_col[0];
                    hist_cnt    <= (hist_cnt == 2'd2) ? 2'd2 : hist_cnt + 2'd1;
`endif
                    chk_cnt <= 2'd0;
                    state   <= CHECK;
                end
                CHECK: begin
                    if (chk_cnt == 2'(CHECK_CYCLES - 1)) begin
                        if (bus.win_p1 || bus.win_p2) begin
                            if (bus.win_p1 && bus.win_p2) begin
                                bus.winner <= mover ? 2'b10 : 2'b01;
                            end else begin
                                bus.winner <= bus.win_p1 ? 2'b01 : 2'b10;
                            end
                            bus.game_over <= 1'b1;
                            state         <= DONE;
                        end else if (board_full_c) begin
                            bus.winner    <= 2'b11;
                            bus.game_over <= 1'b1;
                            state         <= DONE;
                        end else if (!mover) begin
                            bus.player <= 1'b1;
                            ai_timer   <= 8'd0;
                            state      <= bus.sw ? AI_WAIT : WAIT_P2;
                        end else begin
                            // always returns through WAIT_P1 at player 0, so the engine restarts
                            bus.player <= 1'b0;
                            state      <= WAIT_P1;
                        end
                    end else begin
                        chk_cnt <= chk_cnt + 2'd1;
                    end
                end
                DONE: begin
                    state <= DONE;
                end
                default: begin
                    state <= WAIT_P1;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_turn_controller.sv
// Self-checking bench for turn_controller (default build, UNDO_EN undefined).
module tb_turn_controller;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    turn_controller_if bus ();
    turn_controller dut (.clk(clk), .rst(rst), .bus(bus.slave));

    int passed = 0;
    int total  = 0;

    // reference game state: board[col][row] holds 0 empty, 1 p1, 2 p2/AI
    int board [7][6];
    int heights [7];
    int m_player;
    int m_over;
    int m_winner;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [97:0] obs, input logic [97:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    function automatic logic [97:0] exp_grid();
        logic [97:0] g = '0;
        for (int c = 0; c < 7; c++)
            for (int r = 0; r < 6; r++)
                g[r*14 + 12 - 2*c +: 2] = 2'(board[c][r]);
        return g;
    endfunction

    function automatic logic [20:0] exp_counts();
        logic [20:0] cc = '0;
        for (int c = 0; c < 7; c++) cc[c*3 +: 3] = 3'(heights[c]);
        return cc;
    endfunction

    function automatic int lowest_open();
        for (int c = 0; c < 7; c++) if (heights[c] < 6) return c;
        return 0;
    endfunction

    function automatic int all_full();
        for (int c = 0; c < 7; c++) if (heights[c] < 6) return 0;
        return 1;
    endfunction

    task automatic check_state(input string tag);
        chk({tag, ".grid"},      bus.grid,                 exp_grid());
        chk({tag, ".counts"},    98'(bus.column_counts),   98'(exp_counts()));
        chk({tag, ".player"},    98'(bus.player),          98'(m_player));
        chk({tag, ".game_over"}, 98'(bus.game_over),       98'(m_over));
        chk({tag, ".winner"},    98'(bus.winner),          98'(m_winner));
    endtask

    task automatic do_reset(input logic sw_val);
        rst = 1'b1;
        bus.sw = sw_val; bus.btn_drop = 1'b0; bus.sel_col = 3'd0;
        bus.ai_move = 1'b0; bus.ai_opt = 7'd0; bus.win_p1 = 1'b0; bus.win_p2 = 1'b0;
        step(); step();
        rst = 1'b0;
        for (int c = 0; c < 7; c++) begin
            heights[c] = 0;
            for (int r = 0; r < 6; r++) board[c][r] = 0;
        end
        m_player = 0; m_over = 0; m_winner = 0;
    endtask

    // rules applied after any accepted move by the current mover
    task automatic finish_move(input logic wp1, input logic wp2);
        int w;
        if (wp1 && wp2)  w = m_player + 1;
        else if (wp1)    w = 1;
        else if (wp2)    w = 2;
        else if (all_full() != 0) w = 3;
        else             w = 0;
        if (w != 0) begin
            m_winner = w; m_over = 1;
        end else begin
            m_player = 1 - m_player;
        end
    endtask

    task automatic human(input int col, input logic wp1, input logic wp2);
        int geom;
        geom = (col < 7) ? ((heights[col] < 6) ? 1 : 0) : 0;
        bus.sel_col = 3'(col); bus.btn_drop = 1'b1; bus.win_p1 = wp1; bus.win_p2 = wp2;
        step();
        bus.btn_drop = 1'b0;
        chk("illegal_pulse", 98'(bus.illegal), 98'((m_over == 0 && geom == 0) ? 1 : 0));
        if (m_over == 0 && geom != 0) begin
            board[col][heights[col]] = m_player + 1;
            heights[col]++;
            repeat (5) step();
            finish_move(wp1, wp2);
        end else begin
            step();
            chk("illegal_end", 98'(bus.illegal), 98'(0));
        end
        bus.win_p1 = 1'b0; bus.win_p2 = 1'b0;
        check_state("human");
    endtask

    task automatic ai(input int opt, input logic wp1, input logic wp2);
        int col;
        col = (13 - (opt % 14)) / 2;
        if (heights[col] >= 6) col = lowest_open();
        bus.ai_opt = 7'(opt); bus.ai_move = 1'b1; bus.win_p1 = wp1; bus.win_p2 = wp2;
        step();
        bus.ai_move = 1'b0;
        board[col][heights[col]] = 2;
        heights[col]++;
        repeat (5) step();
        finish_move(wp1, wp2);
        bus.win_p1 = 1'b0; bus.win_p2 = 1'b0;
        check_state("ai");
    endtask

    task automatic ai_timeout();
        int n;
        int col;
        repeat (250) step();
        chk("timeout_early", 98'(bus.column_counts), 98'(exp_counts()));
        n = 0;
        while (bus.column_counts == exp_counts() && n < 60) begin
            step();
            n++;
        end
        chk("timeout_fired", 98'(n < 60), 98'(1));
        col = lowest_open();
        board[col][heights[col]] = 2;
        heights[col]++;
        repeat (4) step();
        finish_move(1'b0, 1'b0);
        check_state("timeout");
    endtask

    initial begin
        int c;
        int geom;

        // reset values
        do_reset(1'b1);
        check_state("reset");
        chk("reset.illegal", 98'(bus.illegal), 98'(0));

        // human vs AI opening: p1 col 3, AI opt 20 -> col 3 row 1
        human(3, 1'b0, 1'b0);
        ai(20, 1'b0, 1'b0);

        // randomized human/AI rounds, including illegal picks and full-column fallbacks
        for (int k = 0; k < 8; k++) begin
            for (int t = 0; t < 20; t++) begin
                c = int'($urandom_range(0, 7));
                geom = (c < 7) ? ((heights[c] < 6) ? 1 : 0) : 0;
                human(c, 1'b0, 1'b0);
                if (geom != 0) break;
            end
            ai(int'($urandom_range(0, 127)), 1'b0, 1'b0);
        end

        // full column and out-of-range column rejected; AI on a full column falls back
        do_reset(1'b1);
        repeat (3) begin
            human(0, 1'b0, 1'b0);
            ai(13, 1'b0, 1'b0);
        end
        human(0, 1'b0, 1'b0);
        human(7, 1'b0, 1'b0);
        human(4, 1'b0, 1'b0);
        ai(13, 1'b0, 1'b0);

        // engine silent -> forced fallback to lowest open column
        do_reset(1'b1);
        human(3, 1'b0, 1'b0);
        ai_timeout();

        // p1 wins; afterwards drops and engine moves are ignored
        do_reset(1'b1);
        human(3, 1'b0, 1'b0);
        ai(20, 1'b0, 1'b0);
        human(1, 1'b1, 1'b0);
        human(2, 1'b0, 1'b0);
        bus.ai_move = 1'b1; bus.ai_opt = 7'd20;
        step();
        bus.ai_move = 1'b0;
        repeat (4) step();
        check_state("done_frozen");

        // sw dropped during AI_WAIT -> second human plays with buttons
        do_reset(1'b1);
        human(3, 1'b0, 1'b0);
        bus.sw = 1'b0;
        step(); step();
        human(5, 1'b0, 1'b0);

        // human vs human alternation and simultaneous win flags resolved to mover
        do_reset(1'b0);
        for (int k = 0; k < 6; k++) human(int'($urandom_range(0, 6)), 1'b0, 1'b0);
        human(2, 1'b0, 1'b0);
        human(4, 1'b1, 1'b1);

        // full board with no win -> draw
        do_reset(1'b0);
        for (int col = 0; col < 7; col++)
            for (int r = 0; r < 6; r++)
                human(col, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
